// File: rtl/data_synchronizer_transmitter.sv
// Source-domain CDC sender: registers a word and holds it under a level request until the synchronized ack completes a 4-phase handshake.
// Request visible 1 cycle after accept; data_in_ready low while busy or while a stale ack is still seen.
module data_synchronizer_transmitter #(
  parameter int STAGE_COUNT = 2,
  parameter int BUS_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_in_valid,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 asynchronous_ack,
  output logic                 data_in_ready,
  output logic                 asynchronous_data_valid,
  output logic [BUS_WIDTH-1:0] asynchronous_data,
  output logic                 transfer_done,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [STAGE_COUNT-1:0] ack_sync_q;
  logic                   ack_sync;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[STAGE_COUNT-2:0], asynchronous_ack};
    end
  end

  assign ack_sync = ack_sync_q[STAGE_COUNT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // A stale ack seen in IDLE blocks new requests so the destination cannot
  // mistake the old level for an acknowledge of the next word.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (data_in_valid && !ack_sync) begin
          data_d  = data_in;
          valid_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        valid_d = 1'b1;
        if (ack_sync) begin
          valid_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        valid_d = 1'b0;
        if (!ack_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign data_in_ready           = (state_q == IDLE) && !ack_sync;
  assign busy                    = (state_q != IDLE);
  assign asynchronous_data_valid = valid_q;
  assign asynchronous_data       = data_q;
  assign transfer_done           = done_q;

endmodule

// File: tb/tb_data_synchronizer_transmitter.sv
// Bench for data_synchronizer_transmitter: directed words, destination ack model, request scoreboard.
module tb_data_synchronizer_transmitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       data_in_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       asynchronous_ack;
  logic       data_in_ready;
  logic       asynchronous_data_valid;
  logic [7:0] asynchronous_data;
  logic       transfer_done;
  logic       busy;

  data_synchronizer_transmitter #(.STAGE_COUNT(2), .BUS_WIDTH(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .data_in_valid           (data_in_valid),
    .data_in                 (data_in),
    .asynchronous_ack        (asynchronous_ack),
    .data_in_ready           (data_in_ready),
    .asynchronous_data_valid (asynchronous_data_valid),
    .asynchronous_data       (asynchronous_data),
    .transfer_done           (transfer_done),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  // Destination model: ack is the request level delayed 3 cycles, or forced high.
  logic [2:0] dly = 3'b000;
  logic       force_ack = 1'b0;
  always @(posedge clk) dly <= {dly[1:0], asynchronous_data_valid};
  assign asynchronous_ack = force_ack | dly[2];

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bad(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout or unexpected event at %0t", nm, $time);
  endtask

  // Monitor: pops the expected word on each new request and checks bus stability.
  logic       prev_valid = 1'b0;
  logic       prev_done = 1'b0;
  logic       have_word = 1'b0;
  logic [7:0] cur_word = 8'h00;
  int         done_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      have_word = 1'b0;
    end else begin
      if (asynchronous_data_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          bad("unexpected_req");
        end else begin
          cur_word = exp_q.pop_front();
          have_word = 1'b1;
          chk("req_data", {24'h0, asynchronous_data}, {24'h0, cur_word});
        end
      end else if (have_word && (asynchronous_data_valid || (busy && asynchronous_ack))) begin
        chk("bus_stable", {24'h0, asynchronous_data}, {24'h0, cur_word});
      end
      if (transfer_done) begin
        done_cnt++;
        if (prev_done) bad("done_width");
      end
    end
    prev_valid = asynchronous_data_valid;
    prev_done  = transfer_done;
  end

  task automatic send(input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    data_in = w;
    data_in_valid = 1'b1;
    exp_q.push_back(w);
    while (!data_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) bad("send_timeout");
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || transfer_done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) bad("idle_timeout");
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_valid"}, {31'h0, asynchronous_data_valid}, 32'h0);
    chk({nm, "_data"},  {24'h0, asynchronous_data}, 32'h0);
    chk({nm, "_done"},  {31'h0, transfer_done}, 32'h0);
    chk({nm, "_busy"},  {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int c, fall, done, n, d0;

    // Reset held with data_in_valid toggling.
    repeat (2) @(negedge clk);
    data_in_valid = 1'b1;
    data_in = 8'hC3;
    @(negedge clk);
    chk_reset_vals("rst");
    data_in_valid = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst2");
    chk("rst_ready", {31'h0, data_in_ready}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, data_in_ready}, 32'h1);

    // Single word 0xA5 with timing of the handshake.
    @(negedge clk);
    data_in = 8'hA5;
    data_in_valid = 1'b1;
    exp_q.push_back(8'hA5);
    chk("a5_ready", {31'h0, data_in_ready}, 32'h1);
    @(negedge clk);
    data_in_valid = 1'b0;
    chk("a5_valid_rise", {31'h0, asynchronous_data_valid}, 32'h1);
    chk("a5_busy", {31'h0, busy}, 32'h1);
    chk("a5_ready_low", {31'h0, data_in_ready}, 32'h0);
    c = 0; fall = -1; done = -1;
    while (c < 40 && done < 0) begin
      @(negedge clk);
      c++;
      if (fall < 0 && !asynchronous_data_valid) fall = c;
      if (transfer_done) done = c;
    end
    chk("a5_valid_fall_cycle", fall, 6);
    chk("a5_done_cycle", done, 12);
    chk("a5_ready_back", {31'h0, data_in_ready}, 32'h1);
    chk("a5_data_held", {24'h0, asynchronous_data}, 32'hA5);

    // Back-to-back 0x11, 0x22 with data_in_valid held high.
    @(negedge clk);
    data_in = 8'h11;
    data_in_valid = 1'b1;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    @(negedge clk);
    data_in = 8'h22;
    chk("b2b_first", {24'h0, asynchronous_data}, 32'h11);
    n = 0;
    while (!transfer_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) bad("b2b_done_timeout");
    chk("b2b_done_bus", {24'h0, asynchronous_data}, 32'h11);
    chk("b2b_done_ready", {31'h0, data_in_ready}, 32'h1);
    @(negedge clk);
    chk("b2b_second", {24'h0, asynchronous_data}, 32'h22);
    chk("b2b_second_valid", {31'h0, asynchronous_data_valid}, 32'h1);
    data_in_valid = 1'b0;
    wait_idle();

    // 0xFF pulsed while in REQ is ignored.
    @(negedge clk);
    data_in = 8'h66;
    data_in_valid = 1'b1;
    exp_q.push_back(8'h66);
    @(negedge clk);
    data_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    data_in = 8'hFF;
    data_in_valid = 1'b1;
    chk("ign_ready", {31'h0, data_in_ready}, 32'h0);
    @(negedge clk);
    data_in_valid = 1'b0;
    chk("ign_data", {24'h0, asynchronous_data}, 32'h66);
    wait_idle();
    chk("ign_data_after", {24'h0, asynchronous_data}, 32'h66);
    repeat (3) @(negedge clk);
    chk("ign_no_req", {31'h0, asynchronous_data_valid}, 32'h0);

    // Stuck-high ack across reset release.
    #2 reset = 1'b1;
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("stk_rst");
    #2 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("stk_ready", {31'h0, data_in_ready}, 32'h0);
    data_in = 8'h3C;
    data_in_valid = 1'b1;
    exp_q.push_back(8'h3C);
    repeat (5) @(negedge clk);
    chk("stk_no_req", {31'h0, asynchronous_data_valid}, 32'h0);
    chk("stk_idle", {31'h0, busy}, 32'h0);
    force_ack = 1'b0;
    n = 0;
    while (!data_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) bad("stk_ready_timeout");
    @(negedge clk);
    data_in_valid = 1'b0;
    wait_idle();
    chk("stk_data", {24'h0, asynchronous_data}, 32'h3C);

    // Reset while in RELEASE drops the word without transfer_done.
    send(8'h77);
    n = 0;
    while (!(busy && !asynchronous_data_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) bad("rel_timeout");
    #2 reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rel_rst");
    chk("rel_rst_ready", {31'h0, data_in_ready}, 32'h1);
    d0 = done_cnt;
    #2 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rel_no_done", done_cnt, d0);
    send(8'h5A);
    wait_idle();
    chk("rel_next_data", {24'h0, asynchronous_data}, 32'h5A);

    repeat (5) @(negedge clk);
    chk("done_total", done_cnt, 6);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
